// File: rtl/vec_pipe_stage.sv
// vec_pipe_stage: reusable datapath pipeline register with valid/ready
// back-pressure, a one-entry skid buffer, synchronous flush and a
// saturating stall counter. Main register M drives the outputs; skid
// register S catches the entry accepted while downstream stalls.
module vec_pipe_stage #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CTRL_W    = 8,
    parameter int unsigned ZERO_CTRL = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned DW = LANES * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DW-1:0]     r_m_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DW-1:0]     r_s_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_m_in;
    logic              w_load_m_skid;
    logic              w_load_s;
    logic              w_stalled;

    // Handshake signals derive from registered state only, so in_ready has
    // no combinational dependence on out_ready.
    assign in_ready   = (r_state != ST_TWO);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_stalled  = out_valid & ~out_ready;

    assign out_data   = r_m_data;
    assign stall_cnt  = r_stall_cnt;

    // Bubble handling: optionally force control to zero while no entry is
    // presented so downstream write enables stay inactive.
    always_comb begin
        out_ctrl = r_m_ctrl;
        if ((ZERO_CTRL != 0) && !out_valid) begin
            out_ctrl = '0;
        end
    end

    // Next-state and register-load decode; flush overrides everything and
    // suppresses all loads so an entry accepted this cycle is discarded.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_m_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_TWO;
                    w_load_s    = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt   = ST_ONE;
                    w_load_m_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt   = ST_EMPTY;
            w_load_m_in   = 1'b0;
            w_load_m_skid = 1'b0;
            w_load_s      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid payload registers; M keeps its last value in a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_ctrl <= '0;
            r_m_data <= '0;
            r_s_ctrl <= '0;
            r_s_data <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
            end else if (w_load_m_skid) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
            end
            if (w_load_s) begin
                r_s_ctrl <= in_ctrl;
                r_s_data <= in_data;
            end
        end
    end

    // Saturating count of cycles with a presented but unaccepted entry;
    // only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_pipe_stage.sv
// Testbench for vec_pipe_stage: scenario tasks with inline checks plus a
// queue scoreboard that follows every accepted and delivered entry.
`timescale 1ns/1ps
module tb_vec_pipe_stage;

    localparam int LANES  = 4;
    localparam int WIDTH  = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int DW     = LANES * WIDTH;
    localparam int EW     = CTRL_W + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DW-1:0]     out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    logic [EW-1:0] sb_q[$];

    vec_pipe_stage #(
        .LANES(LANES),
        .WIDTH(WIDTH),
        .CTRL_W(CTRL_W),
        .ZERO_CTRL(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor, sampled on the falling edge between active edges.
    always @(negedge clk) begin
        logic [EW-1:0] exp_e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                fire_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got ctrl=%h data=%h expected no output", out_ctrl, out_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({out_ctrl, out_data} !== exp_e) begin
                        errors++;
                        $display("FAIL sb_order got %h expected %h", {out_ctrl, out_data}, exp_e);
                    end
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_ctrl, in_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input int v);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            d[k*WIDTH +: WIDTH] = WIDTH'(v + k * 256);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b expected 1", in_ready); end
        checks++;
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL rst_out_ctrl got %h expected 00", out_ctrl); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h expected 0", out_data); end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d expected 0", stall_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 8'h05; in_data = d;
        step();
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1", out_valid); end
        checks++;
        if (out_ctrl !== 8'h05) begin errors++; $display("FAIL single_ctrl got %h expected 05", out_ctrl); end
        chk("single_data", out_data, d);
        step();
        checks++;
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL bubble_ctrl got %h expected 00", out_ctrl); end
        chk("bubble_data_hold", out_data, d);
    endtask

    task automatic test_stream();
        int f0;
        f0 = fire_cnt;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = CTRL_W'(i); in_data = mk(i);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (fire_cnt - f0 != 8) begin errors++; $display("FAIL stream_fires got %0d expected 8", fire_cnt - f0); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hA1; in_data = mk(32'hA1);
        step();
        in_ctrl = 8'hA2; in_data = mk(32'hA2);
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
        in_ctrl = 8'hA3; in_data = mk(32'hA3);
        step(); step(); step(); step();
        in_valid = 1'b0;
        checks++;
        if (stall_cnt !== 4'd5) begin errors++; $display("FAIL stall_cnt5 got %0d expected 5", stall_cnt); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_held_ready got %b expected 0", in_ready); end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b expected 1", in_ready); end
        chk("drain_second", out_data, mk(32'hA2));
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hF1; in_data = mk(32'hF01);
        step();
        in_ctrl = 8'hF2; in_data = mk(32'hF02);
        step();
        in_ctrl = 8'hF3; in_data = mk(32'hF03);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b expected 0", out_valid); end
        checks++;
        if (out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %h expected 00", out_ctrl); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b expected 1", in_ready); end
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got valid=%b data=%h expected valid 0", out_valid, out_data); end
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hB1; in_data = mk(32'hB1);
        step();
        in_ctrl = 8'hB2; in_data = mk(32'hB2);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        in_valid = 1'b1; in_ctrl = 8'hC1; in_data = mk(32'hC1);
        step();
        in_ctrl = 8'hC2; in_data = mk(32'hC2);
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 6; n++) step();
        checks++;
        if (stall_cnt !== 4'd7) begin errors++; $display("FAIL pre_rst_cnt got %0d expected 7", stall_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b expected 1", in_ready); end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d expected 0", stall_cnt); end
        chk("rst_mid_data", out_data, '0);
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hD1; in_data = mk(32'hD1);
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 14; n++) step();
        checks++;
        if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d expected 14", stall_cnt); end
        for (int n = 0; n < 5; n++) step();
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d expected 15", stall_cnt); end
        out_ready = 1'b1;
        step();
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d expected 15", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 10 && (sb_q.size() != 0 || out_valid); n++) step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending expected 0", sb_q.size()); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_rst_mid();
        test_saturate();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
